// File: rtl/mux_pkg.sv
// Shared types and helpers for the multiplexed-input scan sampler.
package mux_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    HOLD
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } next_ch_t;

  // Lowest enabled channel strictly above 'from'; pass -1 to get the lowest overall.
  function automatic next_ch_t next_enabled(input logic [N_CH-1:0] mask, input int from);
    next_ch_t res;
    res = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (mask[i] && (i > from)) begin
        res.found = 1'b1;
        res.idx   = SEL_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_sampler.sv
// Steps an external 4:1 mux through the enabled channels, lets each select settle,
// samples the returned bit and presents the assembled word with a valid/ready handshake.
module mux_scan_sampler #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned N_CH          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [N_CH-1:0]           mask,
  output logic [mux_pkg::SEL_W-1:0] mux_sel,
  input  logic                      mux_y,
  output logic [N_CH-1:0]           data,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      busy
);

  import mux_pkg::SEL_W;
  import mux_pkg::CNT_W;
  import mux_pkg::state_e;
  import mux_pkg::IDLE;
  import mux_pkg::SETTLE;
  import mux_pkg::SAMPLE;
  import mux_pkg::HOLD;
  import mux_pkg::next_ch_t;
  import mux_pkg::next_enabled;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]   shadow_q, shadow_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [N_CH-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  next_ch_t          first_ch;
  next_ch_t          restart_ch;
  next_ch_t          step_ch;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    data_d   = data_q;
    valid_d  = valid_q;

    first_ch   = next_enabled(mask, -1);
    restart_ch = next_enabled(mask_q, -1);
    step_ch    = next_enabled(mask_q, int'(sel_q));

    case (state_q)
      IDLE: begin
        // found is only set when the incoming mask has at least one enabled channel
        if (start && first_ch.found) begin
          mask_d   = mask;
          sel_d    = first_ch.idx;
          cnt_d    = RELOAD;
          shadow_d = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SAMPLE: begin
        shadow_d[sel_q] = mux_y;
        if (step_ch.found) begin
          sel_d   = step_ch.idx;
          cnt_d   = RELOAD;
          state_d = SETTLE;
        end else begin
          data_d  = shadow_d;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && data_ready) begin
          valid_d = 1'b0;
          if (continuous && restart_ch.found) begin
            sel_d    = restart_ch.idx;
            cnt_d    = RELOAD;
            shadow_d = '0;
            state_d  = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      mask_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign mux_sel    = sel_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: doc/mux_scan_sampler.md
MUX_SCAN_SAMPLER -- requirements
Module: mux_scan_sampler

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, number of cycles the select is held stable before sampling; legal range 1..15.
REQ-002 Parameter N_CH, default 4, number of mux channels; fixed at 4 for this revision.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
REQ-006 continuous  input  1  restart a scan automatically after each accepted result; sampled at handshake.
REQ-007 mask  input  4  channel enable, bit i enables channel i; latched at start.
REQ-008 mux_sel  output  2  select driven to the downstream 4:1 mux.
REQ-009 mux_y  input  1  selected mux output returned to this block.
REQ-010 data  output  4  scan result, bit i = sampled value of channel i; disabled channels read 0.
REQ-011 data_valid  output  1  result available; held until accepted.
REQ-012 data_ready  input  1  consumer accepts data when high together with data_valid.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, SAMPLE and HOLD.
REQ-015 IDLE: start=1 and mask!=0 -> latch mask, mux_sel = lowest enabled channel, settle counter = SETTLE_CYCLES-1, go to SETTLE; start with mask==0 SHALL be ignored.
REQ-016 SETTLE: mux_sel held constant; counter decrements each cycle; at 0 -> SAMPLE, so SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-017 SAMPLE (one cycle): mux_y captured into shadow bit [mux_sel]; if a higher enabled channel exists, mux_sel = next higher enabled channel, counter reloaded, -> SETTLE; otherwise data = shadow including the bit captured this edge, data_valid = 1, -> HOLD.
REQ-018 Scan latency: for N enabled channels and start sampled at edge T, data_valid SHALL rise at edge T + N*(SETTLE_CYCLES+1).
REQ-019 Shadow bits of disabled channels SHALL be 0; shadow is cleared at every scan start.
REQ-020 HOLD: data and data_valid stable until data_valid & data_ready; data_ready while not in HOLD has no effect.
REQ-021 On handshake with continuous=1: restart using the latched mask (no new start needed), data_valid = 0 on the same edge, -> SETTLE on lowest enabled channel.
REQ-022 On handshake with continuous=0: data_valid = 0, -> IDLE; data keeps its last value.
REQ-023 start outside IDLE SHALL be ignored; mask changes outside IDLE SHALL not affect the scan in progress.
REQ-024 mux_sel SHALL change only on SAMPLE->SETTLE, IDLE->SETTLE and HOLD->SETTLE transitions; it holds its value in IDLE and HOLD.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, mux_sel=0, data=0, data_valid=0, busy=0, counter=0, shadow=0, latched mask=0, including mid-scan and during HOLD.
REQ-026 After rst_n deasserts, the first start is accepted on the first rising edge at which it is sampled high.

Structure
REQ-027 Shared package mux_pkg SHALL hold the state enumeration, N_CH=4, SEL_W=2 and the next-enabled-channel function (lowest enabled channel strictly above a given index, with a found flag).
REQ-028 The block is a single module with no sub-module instances; the 4:1 mux is external and is instantiated only in the testbench.

Verification
REQ-029 mask=1111, SETTLE_CYCLES=1, mux inputs 4'b1010, start at edge T -> mux_sel sequence 0,1,2,3; data=1010 with data_valid rising at edge T+8.
REQ-030 mask=0101, SETTLE_CYCLES=3, mux inputs 4'b1111 -> only channels 0 and 2 selected; data=0101; data_valid at T+8; mux_sel holds each channel for 4 cycles.
REQ-031 mask=0000 with start pulse -> remains IDLE, busy=0, mux_sel=0, data_valid never asserts.
REQ-032 continuous=1, mask=1000, data_ready held low 5 cycles after data_valid -> data stable for those 5 cycles; on the handshake a new scan starts with no start, next data_valid 2 cycles later (SETTLE_CYCLES=1).
REQ-033 rst_n pulsed low during SETTLE of channel 2 -> all outputs 0 asynchronously; after release, start with mask=0010 gives data=0010 for mux inputs 4'b0010.
REQ-034 start asserted and mask changed to 0001 while busy with mask=1100 -> both ignored; result covers channels 2 and 3 only.
